// File: rtl/apb_cmd_master.sv
// apb_cmd_master: buffers valid/ready commands in a small FIFO and replays them as APB transfers.
// Latency: push at edge N -> SETUP after N+1 -> ACCESS after N+2 -> read capture at N+1+ACCESS_CYCLES+1.
// Backpressure: cmd_ready = !full (registered count); a full FIFO refuses a push even when it pops on the same edge.
//
// Ports:
//   PCLK, PRESETn                        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready                  command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid/rsp_rdata                  one-cycle read-completion pulse, data held until next read
//   busy                                 FIFO non-empty or a transfer in flight
//   PADDR/PSELx/PENABLE/PWRITE/PWDATA    APB request; PRDATA APB read data
//
// Optional feature: define APB_CMD_MASTER_BACK2BACK_EN to chain queued transfers
// ACCESS -> SETUP without an intervening IDLE cycle.
// ADDR_W/DATA_W default to `addrWidth/`dataWidth (normally from macros.vh);
// fallbacks are provided when those are not defined.

`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

module apb_cmd_master #(
  parameter int ADDR_W        = `addrWidth,
  parameter int DATA_W        = `dataWidth,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Command FIFO: entry layout {write, addr, wdata}
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [1:0]       state;
  logic [3:0]       acc_cnt;
  logic             last_access;

  logic [ENT_W-1:0]  head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = cmd_valid && !full;

  assign last_access = (state == ACCESS) && (acc_cnt == 4'd0);

`ifdef APB_CMD_MASTER_BACK2BACK_EN
  // Final ACCESS edge may pop the next command straight into SETUP.
  assign pop = !empty && ((state == IDLE) || last_access);
`else
  assign pop = !empty && (state == IDLE);
`endif

  assign head       = fifo_mem[rd_ptr];
  assign head_write = head[ENT_W-1];
  assign head_addr  = head[ENT_W-2 -: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      acc_cnt   <= 4'd0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;

      // Request fields only move when a command enters SETUP.
      if (pop) begin
        PADDR  <= head_addr;
        PWRITE <= head_write;
        PWDATA <= head_write ? head_wdata : '0;
      end

      case (state)
        IDLE: begin
          if (pop) state <= SETUP;
        end
        SETUP: begin
          state   <= ACCESS;
          acc_cnt <= 4'(ACCESS_CYCLES - 1);
        end
        ACCESS: begin
          if (acc_cnt == 4'd0) begin
            if (!PWRITE) begin
              rsp_rdata <= PRDATA;
              rsp_valid <= 1'b1;
            end
            // pop is only true here when back-to-back chaining is built in.
            state <= pop ? SETUP : IDLE;
          end else begin
            acc_cnt <= acc_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset drops them asynchronously.
  assign PSELx     = (state != IDLE);
  assign PENABLE   = (state == ACCESS);
  assign busy      = !empty || (state != IDLE);
  assign cmd_ready = !full;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed checks of three apb_cmd_master instances (ACCESS_CYCLES 1, 15, 3).
// Each instance talks to a small behavioural APB slave in this file.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.

module tb_apb_cmd_master;

  localparam int AW = 8;
  localparam int DW = 16;

  logic pclk = 1'b0;
  logic presetn;

  always #5 pclk = ~pclk;

  // ---------------- instance 1: ACCESS_CYCLES = 1 ----------------
  logic          cv1, cw1, crdy1, rv1, busy1, psel1, pen1, pwr1;
  logic [AW-1:0] ca1, paddr1;
  logic [DW-1:0] cd1, rd1, pwd1, prd1;
  logic [DW-1:0] mem1 [256];

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .ACCESS_CYCLES(1)) u_dut1 (
    .PCLK(pclk), .PRESETn(presetn),
    .cmd_valid(cv1), .cmd_ready(crdy1), .cmd_write(cw1), .cmd_addr(ca1), .cmd_wdata(cd1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1),
    .PADDR(paddr1), .PSELx(psel1), .PENABLE(pen1), .PWRITE(pwr1), .PWDATA(pwd1), .PRDATA(prd1)
  );

  always @(posedge pclk) if (psel1 && pen1 && pwr1) mem1[paddr1] <= pwd1;
  assign prd1 = mem1[paddr1];

  // ---------------- instance 2: ACCESS_CYCLES = 15 (stalled bus) ----------------
  logic          cv2, cw2, crdy2, rv2, busy2, psel2, pen2, pwr2;
  logic [AW-1:0] ca2, paddr2;
  logic [DW-1:0] cd2, rd2, pwd2;
  logic [DW-1:0] prd2 = 16'h0;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .ACCESS_CYCLES(15)) u_dut2 (
    .PCLK(pclk), .PRESETn(presetn),
    .cmd_valid(cv2), .cmd_ready(crdy2), .cmd_write(cw2), .cmd_addr(ca2), .cmd_wdata(cd2),
    .rsp_valid(rv2), .rsp_rdata(rd2), .busy(busy2),
    .PADDR(paddr2), .PSELx(psel2), .PENABLE(pen2), .PWRITE(pwr2), .PWDATA(pwd2), .PRDATA(prd2)
  );

  logic [AW-1:0] seen2[$];
  int run2 = 0;
  int last_run2 = 0;
  always @(negedge pclk) begin
    if (psel2 && !pen2) seen2.push_back(paddr2);
    if (pen2) run2++;
    else begin
      if (run2 != 0) last_run2 = run2;
      run2 = 0;
    end
  end

  // ---------------- instance 3: ACCESS_CYCLES = 3 ----------------
  logic          cv3, crdy3, rv3, busy3, psel3, pen3, pwr3;
  logic [AW-1:0] paddr3;
  logic [DW-1:0] rd3, pwd3, prd3;
  logic [DW-1:0] acc3 = 16'h0;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .ACCESS_CYCLES(3)) u_dut3 (
    .PCLK(pclk), .PRESETn(presetn),
    .cmd_valid(cv3), .cmd_ready(crdy3), .cmd_write(cw2), .cmd_addr(ca2), .cmd_wdata(cd2),
    .rsp_valid(rv3), .rsp_rdata(rd3), .busy(busy3),
    .PADDR(paddr3), .PSELx(psel3), .PENABLE(pen3), .PWRITE(pwr3), .PWDATA(pwd3), .PRDATA(prd3)
  );

  // Read data changes every ACCESS cycle so the sampling cycle is visible.
  always @(posedge pclk) acc3 <= pen3 ? acc3 + 16'd1 : 16'd0;
  assign prd3 = 16'h3000 | acc3;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int pushed;
    int low;
    logic took;

    presetn = 1'b0;
    cv1 = 1'b1; cw1 = 1'b1; ca1 = 8'h55; cd1 = 16'h5555;
    cv2 = 1'b0; cw2 = 1'b1; ca2 = '0; cd2 = '0;
    cv3 = 1'b0;

    // Reset: cmd_valid held high must be ignored.
    tick(); tick();
    chk("rst_psel",    32'(psel1),  32'd0);
    chk("rst_penable", 32'(pen1),   32'd0);
    chk("rst_pwrite",  32'(pwr1),   32'd0);
    chk("rst_paddr",   32'(paddr1), 32'd0);
    chk("rst_pwdata",  32'(pwd1),   32'd0);
    chk("rst_rsp_vld", 32'(rv1),    32'd0);
    chk("rst_rdata",   32'(rd1),    32'd0);
    chk("rst_busy",    32'(busy1),  32'd0);
    chk("rst_ready",   32'(crdy1),  32'd1);
    cv1 = 1'b0;
    #3 presetn = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy1), 32'd0);

    // Write through: addr 1 <- 1, addr 4 <- 144.
    cv1 = 1'b1; cw1 = 1'b1; ca1 = 8'd1; cd1 = 16'd1;
    tick();                                   // edge N: push #1
    chk("wr_idle_psel", 32'(psel1), 32'd0);
    chk("wr_busy",      32'(busy1), 32'd1);
    ca1 = 8'd4; cd1 = 16'd144;
    tick();                                   // N+1: pop #1 -> SETUP, push #2
    cv1 = 1'b0;
    chk("wr1_setup_psel", 32'(psel1),  32'd1);
    chk("wr1_setup_pen",  32'(pen1),   32'd0);
    chk("wr1_paddr",      32'(paddr1), 32'd1);
    chk("wr1_pwdata",     32'(pwd1),   32'd1);
    chk("wr1_pwrite",     32'(pwr1),   32'd1);
    tick();                                   // N+2: ACCESS
    chk("wr1_access_pen", 32'(pen1), 32'd1);
    tick();
`ifdef APB_CMD_MASTER_BACK2BACK_EN
    chk("wr2_b2b_psel", 32'(psel1), 32'd1);
`else
    chk("wr_gap_psel", 32'(psel1), 32'd0);
    tick();
`endif
    chk("wr2_setup_pen", 32'(pen1),   32'd0);
    chk("wr2_paddr",     32'(paddr1), 32'd4);
    chk("wr2_pwdata",    32'(pwd1),   32'd144);
    tick();
    chk("wr2_access_pen", 32'(pen1), 32'd1);
    tick();
    chk("wr_done_busy", 32'(busy1), 32'd0);
    chk("wr_done_psel", 32'(psel1), 32'd0);

    // Readback of addr 4.
    cv1 = 1'b1; cw1 = 1'b0; ca1 = 8'd4; cd1 = 16'hDEAD;
    tick();                                   // N: push
    cv1 = 1'b0;
    tick();                                   // N+1: SETUP
    chk("rd_pwrite", 32'(pwr1),   32'd0);
    chk("rd_pwdata", 32'(pwd1),   32'd0);
    chk("rd_paddr",  32'(paddr1), 32'd4);
    chk("rd_rv_setup", 32'(rv1),  32'd0);
    tick();                                   // N+2: ACCESS
    chk("rd_rv_access", 32'(rv1), 32'd0);
    tick();                                   // N+3: capture
    chk("rd_rv_pulse", 32'(rv1), 32'd1);
    chk("rd_rdata",    32'(rd1), 32'd144);
    tick();
    chk("rd_rv_end",   32'(rv1), 32'd0);
    chk("rd_rdata_hold", 32'(rd1), 32'd144);

    // FIFO full on the stalled instance: 1 command starts the bus, 4 fill the FIFO.
    cv2 = 1'b1; cw2 = 1'b1; ca2 = 8'h10; cd2 = 16'h1000;
    pushed = 0;
    low = 0;
    for (int c = 0; c < 100 && pushed < 6; c++) begin
      took = crdy2;
      tick();
      if (took) begin
        pushed++;
        ca2 = 8'(8'h10 + pushed);
        cd2 = 16'(16'h1000 + pushed);
        if (pushed == 5) chk("full_ready_low", 32'(crdy2), 32'd0);
        if (pushed == 6) cv2 = 1'b0;
      end else begin
        low++;
      end
    end
    cv2 = 1'b0;
    chk("full_pushed",     32'(pushed), 32'd6);
    chk("full_low_cycles", 32'(low),    32'd14);
    for (int c = 0; c < 200 && busy2; c++) tick();
    chk("full_drained", 32'(busy2), 32'd0);
    chk("full_order_n", 32'(seen2.size()), 32'd6);
    for (int i = 0; i < 6 && i < seen2.size(); i++)
      chk($sformatf("full_order_%0d", i), 32'(seen2[i]), 32'(8'h10 + i));
    chk("acc15_pen_len", 32'(last_run2), 32'd15);

    // ACCESS_CYCLES = 3 read: PENABLE 3 cycles, data sampled at end of the 3rd.
    cw2 = 1'b0; ca2 = 8'h33; cd2 = 16'hBEEF;
    cv3 = 1'b1;
    tick();
    cv3 = 1'b0;
    tick();
    chk("ac3_setup_psel", 32'(psel3), 32'd1);
    chk("ac3_setup_pen",  32'(pen3),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ac3_pen_%0d", i), 32'(pen3), 32'd1);
      chk($sformatf("ac3_rv_%0d", i),  32'(rv3),  32'd0);
    end
    tick();
    chk("ac3_pen_off", 32'(pen3), 32'd0);
    chk("ac3_rv",      32'(rv3),  32'd1);
    chk("ac3_rdata",   32'(rd3),  32'h3002);

`ifdef APB_CMD_MASTER_BACK2BACK_EN
    // Three queued writes chain SETUP/ACCESS with PSELx held.
    cv1 = 1'b1; cw1 = 1'b1; ca1 = 8'h20; cd1 = 16'h0020;
    tick();
    ca1 = 8'h21;
    tick();
    ca1 = 8'h22;
    chk("b2b_psel_0", 32'(psel1), 32'd1);
    chk("b2b_pen_0",  32'(pen1),  32'd0);
    tick();
    cv1 = 1'b0;
    for (int i = 1; i < 6; i++) begin
      if (i > 1) tick();
      chk($sformatf("b2b_psel_%0d", i), 32'(psel1), 32'd1);
      chk($sformatf("b2b_pen_%0d", i),  32'(pen1),  32'(i % 2));
    end
    tick();
    chk("b2b_end_psel", 32'(psel1), 32'd0);
`endif

    // Reset in the middle of a read ACCESS.
    cv1 = 1'b1; cw1 = 1'b0; ca1 = 8'd1;
    tick();
    cv1 = 1'b0;
    tick();                                   // SETUP
    tick();                                   // ACCESS
    chk("mr_in_access", 32'(pen1), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("mr_psel_async", 32'(psel1), 32'd0);
    chk("mr_pen_async",  32'(pen1),  32'd0);
    chk("mr_busy",       32'(busy1), 32'd0);
    chk("mr_rv",         32'(rv1),   32'd0);
    tick();
    chk("mr_rv_held", 32'(rv1), 32'd0);
    #3 presetn = 1'b1;
    tick();
    chk("mr_rel_rv",    32'(rv1),   32'd0);
    chk("mr_rel_busy",  32'(busy1), 32'd0);
    chk("mr_rel_ready", 32'(crdy1), 32'd1);
    chk("mr_rel_psel",  32'(psel1), 32'd0);
    tick();
    chk("mr_rel_rv2", 32'(rv1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
